// File: rtl/bus_arbiter.sv
// Shared system-bus arbiter: 6502 core by default, MARIA DMA and the cart/RAM loader by request.
// The CPU is halted only at a bus-cycle boundary; every output is registered on sysclk.
module bus_arbiter #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TURN_CYC   = 1,
  parameter int unsigned MAX_DMA    = 430
) (
  input  logic sysclk,
  input  logic RES_n,
  input  logic cpu_cyc_end,
  input  logic dma_req,
  input  logic dma_done,
  input  logic load_req,
  input  logic load_done,
  output logic halt_b,
  output logic drive_AB,
  output logic fast_clk_sel,
  output logic dma_gnt,
  output logic load_gnt,
  output logic dma_abort,
  output logic busy
);

  localparam logic [2:0] ST_CPU       = 3'd0;
  localparam logic [2:0] ST_WAIT_EDGE = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_GRANT     = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd4;

  localparam logic OWN_DMA  = 1'b0;
  localparam logic OWN_LOAD = 1'b1;

  localparam logic [8:0] SETTLE_INIT = 9'(SETTLE_CYC - 1);
  localparam logic [8:0] TURN_INIT   = 9'(TURN_CYC - 1);
  localparam logic [8:0] DMA_LIMIT   = 9'(MAX_DMA - 1);

  logic [2:0] state;
  logic [8:0] cnt;
  logic       owner;
  logic       dma_rearm;

  logic       dma_q;
  logic       wait_owner;
  logic       wait_req;
  logic       grant_end;
  logic       abort_hit;

  always_comb begin
    dma_q      = dma_req & dma_rearm;
    wait_owner = owner;
    if (owner == OWN_LOAD && dma_q)
      wait_owner = OWN_DMA;
    wait_req   = (wait_owner == OWN_DMA) ? dma_req : load_req;
    abort_hit  = 1'b0;
    if (owner == OWN_DMA) begin
      // done (or request drop) outranks the limit, so no abort on a simultaneous done
      abort_hit = dma_req & ~dma_done & (cnt == DMA_LIMIT);
      grant_end = dma_done | ~dma_req | abort_hit;
    end else begin
      grant_end = load_done | ~load_req;
    end
  end

  always_ff @(posedge sysclk or negedge RES_n) begin
    if (!RES_n) begin
      state        <= ST_CPU;
      cnt          <= '0;
      owner        <= OWN_DMA;
      dma_rearm    <= 1'b1;
      halt_b       <= 1'b1;
      drive_AB     <= 1'b0;
      fast_clk_sel <= 1'b0;
      dma_gnt      <= 1'b0;
      load_gnt     <= 1'b0;
      dma_abort    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dma_abort <= 1'b0;
      case (state)
        ST_CPU: begin
          if (dma_q) begin
            owner <= OWN_DMA;
            state <= ST_WAIT_EDGE;
            busy  <= 1'b1;
          end else if (load_req) begin
            owner <= OWN_LOAD;
            state <= ST_WAIT_EDGE;
            busy  <= 1'b1;
          end
        end
        ST_WAIT_EDGE: begin
          owner <= wait_owner;
          if (!wait_req) begin
            state <= ST_CPU;
            busy  <= 1'b0;
          end else if (cpu_cyc_end) begin
            halt_b <= 1'b0;
            cnt    <= SETTLE_INIT;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            dma_gnt      <= (owner == OWN_DMA);
            load_gnt     <= (owner == OWN_LOAD);
            drive_AB     <= 1'b1;
            fast_clk_sel <= 1'b1;
            state        <= ST_GRANT;
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        ST_GRANT: begin
          if (cnt != '1)
            cnt <= cnt + 9'd1;
          if (grant_end) begin
            dma_gnt      <= 1'b0;
            load_gnt     <= 1'b0;
            drive_AB     <= 1'b0;
            fast_clk_sel <= 1'b0;
            dma_abort    <= abort_hit;
            cnt          <= TURN_INIT;
            state        <= ST_RELEASE;
            if (owner == OWN_DMA)
              dma_rearm <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (cnt == '0) begin
            // a DMA request queued behind a loader burst keeps the CPU halted
            if (owner == OWN_LOAD && dma_q) begin
              owner <= OWN_DMA;
              cnt   <= SETTLE_INIT;
              state <= ST_SETTLE;
            end else begin
              halt_b <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_CPU;
            end
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        default: begin
          state        <= ST_CPU;
          halt_b       <= 1'b1;
          drive_AB     <= 1'b0;
          fast_clk_sel <= 1'b0;
          dma_gnt      <= 1'b0;
          load_gnt     <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
      // a low request re-arms DMA even on the cycle its grant ends
      if (!dma_req)
        dma_rearm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected output vectors are queued with their cycle
// when stimulus is planned, then popped and compared as the DUT reaches that cycle.
module tb_bus_arbiter;

  logic sysclk;
  logic RES_n;
  logic cpu_cyc_end, dma_req, dma_done, load_req, load_done;
  logic halt_b, drive_AB, fast_clk_sel, dma_gnt, load_gnt, dma_abort, busy;
  logic [6:0] outv;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned at;
    logic [6:0]  val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  bus_arbiter #(.SETTLE_CYC(2), .TURN_CYC(1), .MAX_DMA(430)) dut (
    .sysclk(sysclk), .RES_n(RES_n), .cpu_cyc_end(cpu_cyc_end),
    .dma_req(dma_req), .dma_done(dma_done), .load_req(load_req), .load_done(load_done),
    .halt_b(halt_b), .drive_AB(drive_AB), .fast_clk_sel(fast_clk_sel),
    .dma_gnt(dma_gnt), .load_gnt(load_gnt), .dma_abort(dma_abort), .busy(busy)
  );

  // {halt_b, dma_gnt, load_gnt, drive_AB, fast_clk_sel, dma_abort, busy}
  assign outv = {halt_b, dma_gnt, load_gnt, drive_AB, fast_clk_sel, dma_abort, busy};

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic push(input int unsigned at, input logic [6:0] val, input string tag);
    exp_t x;
    x.at = at; x.val = val; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    RES_n = 1'b0;
    cpu_cyc_end = 0; dma_req = 0; dma_done = 0; load_req = 0; load_done = 0;
    repeat (3) tick();
    checks++;
    if (outv !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_vals: got %b expected %b", outv, 7'b1000000);
    end
    RES_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (outv !== 7'b1000000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", outv, 7'b1000000);
    end
  endtask

  task automatic test_dma_basic();
    int unsigned b = cyc;
    push(b + 5,  7'b1000001, "dma_wait_edge");
    push(b + 11, 7'b0000001, "dma_halt");
    push(b + 12, 7'b0000001, "dma_settle");
    push(b + 13, 7'b0101101, "dma_grant");
    push(b + 40, 7'b0101101, "dma_grant_hold");
    push(b + 41, 7'b0000001, "dma_release");
    push(b + 42, 7'b1000000, "dma_cpu_back");
    dma_req = 1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      while (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); checks++;
        if (outv !== e.val) begin
          errors++; $display("FAIL %s @%0d: got %b expected %b", e.tag, cyc, outv, e.val);
        end
      end
      cpu_cyc_end = (i == 10); dma_done = (i == 40); dma_req = (i < 41);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL dma_basic_pending: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_priority();
    int unsigned b = cyc;
    push(b + 6,  7'b0101101, "prio_dma_wins");
    push(b + 11, 7'b0000001, "prio_dma_release");
    push(b + 12, 7'b1000000, "prio_cpu");
    push(b + 13, 7'b1000001, "prio_load_wait");
    push(b + 17, 7'b0000001, "prio_load_settle");
    push(b + 18, 7'b0011101, "prio_load_grant");
    push(b + 21, 7'b0000001, "prio_load_release");
    push(b + 22, 7'b1000000, "prio_load_cpu");
    dma_req = 1; load_req = 1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      while (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); checks++;
        if (outv !== e.val) begin
          errors++; $display("FAIL %s @%0d: got %b expected %b", e.tag, cyc, outv, e.val);
        end
      end
      cpu_cyc_end = (i == 3 || i == 15);
      dma_done = (i == 10); dma_req = (i < 10);
      load_done = (i == 20); load_req = (i < 20);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL priority_pending: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    int unsigned b = cyc;
    push(b + 5,  7'b0011101, "b2b_load_grant");
    push(b + 12, 7'b0011101, "b2b_no_preempt");
    push(b + 16, 7'b0000001, "b2b_release_halted");
    push(b + 17, 7'b0000001, "b2b_settle1");
    push(b + 18, 7'b0000001, "b2b_settle2");
    push(b + 19, 7'b0101101, "b2b_dma_grant");
    push(b + 26, 7'b0000001, "b2b_dma_release");
    push(b + 27, 7'b1000000, "b2b_cpu");
    load_req = 1;
    for (int i = 1; i <= 29; i++) begin
      tick();
      while (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); checks++;
        if (outv !== e.val) begin
          errors++; $display("FAIL %s @%0d: got %b expected %b", e.tag, cyc, outv, e.val);
        end
      end
      cpu_cyc_end = (i == 2);
      load_done = (i == 15); load_req = (i < 15);
      dma_done = (i == 25); dma_req = (i >= 7 && i < 25);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_abort();
    int unsigned b = cyc;
    push(b + 5,   7'b0101101, "abort_grant");
    push(b + 200, 7'b0101101, "abort_mid_grant");
    push(b + 434, 7'b0101101, "abort_last_grant");
    push(b + 435, 7'b0000011, "abort_pulse");
    push(b + 436, 7'b1000000, "abort_cpu");
    push(b + 437, 7'b1000000, "abort_single_pulse");
    push(b + 441, 7'b1000000, "abort_no_retrigger");
    dma_req = 1;
    for (int i = 1; i <= 447; i++) begin
      tick();
      while (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); checks++;
        if (outv !== e.val) begin
          errors++; $display("FAIL %s @%0d: got %b expected %b", e.tag, cyc, outv, e.val);
        end
      end
      cpu_cyc_end = (i == 2 || i == 440);
      dma_req = (i < 445);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL abort_pending: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_no_retrigger();
    int unsigned b = cyc;
    push(b + 5,  7'b0101101, "rearm_grant1");
    push(b + 9,  7'b0000001, "rearm_release");
    push(b + 10, 7'b1000000, "rearm_cpu");
    push(b + 16, 7'b1000000, "rearm_stale_ignored");
    push(b + 23, 7'b1000001, "rearm_new_req");
    push(b + 26, 7'b0000001, "rearm_halt2");
    push(b + 28, 7'b0101101, "rearm_grant2");
    push(b + 31, 7'b0000001, "rearm_release2");
    push(b + 32, 7'b1000000, "rearm_cpu2");
    dma_req = 1;
    for (int i = 1; i <= 34; i++) begin
      tick();
      while (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); checks++;
        if (outv !== e.val) begin
          errors++; $display("FAIL %s @%0d: got %b expected %b", e.tag, cyc, outv, e.val);
        end
      end
      cpu_cyc_end = (i == 2 || i == 15 || i == 25);
      dma_done = (i == 8 || i == 30);
      dma_req = (i < 20) || (i >= 22 && i < 30);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rearm_pending: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_async_reset();
    int unsigned b = cyc;
    push(b + 10, 7'b0101101, "areset_pre_grant");
    for (int k = 11; k <= 14; k++) push(b + k, 7'b1000001, "drop_wait_edge");
    for (int k = 15; k <= 20; k++) push(b + k, 7'b1000000, "drop_no_halt");
    dma_req = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      while (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); checks++;
        if (outv !== e.val) begin
          errors++; $display("FAIL %s @%0d: got %b expected %b", e.tag, cyc, outv, e.val);
        end
      end
      if (i == 10) begin
        #2 RES_n = 1'b0;
        #1;
        checks++;
        if (outv !== 7'b1000000) begin
          errors++; $display("FAIL areset_immediate: got %b expected %b", outv, 7'b1000000);
        end
        #2 RES_n = 1'b1;
      end
      cpu_cyc_end = (i == 2 || i == 14);
      dma_req = (i < 14);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL areset_pending: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_dma_basic();
    test_priority();
    test_back_to_back();
    test_abort();
    test_no_retrigger();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
